game_sequencer: RTL and testbench

- Top-level control FSM for the 160x120 scrolling-game datapath.
- Generates core_state (WAIT/PLAY/END) and the per-pixel play_state sequence.
- Reacts to the datapath's sig_collision and sig_next_frame.
- Owns the player position, frame pacing (cycles_per_frame) and the survival score; sits between the board keys and the datapath.

---
 rtl/game_sequencer_pkg.sv | 49 ++++
 rtl/game_sequencer_if.sv | 37 +++
 rtl/game_sequencer_key_sync_edge.sv | 42 ++++
 rtl/game_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_game_sequencer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// game_sequencer_pkg
//   Shared encodings and constants for the scrolling-game control path.
//   The outer/inner state encodings are the exact values the datapath decodes
//   from core_state / play_state, so they must not be renumbered.
//   Contents:
//     outer_state_t  - O_S_WAIT / O_S_PLAY / O_S_END
//     inner_state_t  - I_S_INITIALIZE .. I_S_NEXT_PIXEL
//     screen geometry (SCREEN_W, PLAY_H, SCREEN_H) and derived last-pixel
//     coordinates
//     sped_up_period - next frame period after one speed-up, clamped
// -----------------------------------------------------------------------------
package game_sequencer_pkg;

   typedef enum logic [1:0] {
      O_S_WAIT = 2'd0,
      O_S_PLAY = 2'd1,
      O_S_END  = 2'd2
   } outer_state_t;

   typedef enum logic [2:0] {
      I_S_INITIALIZE = 3'd0,
      I_S_READ_NEXT  = 3'd1,
      I_S_READ       = 3'd2,
      I_S_WRITE_HERE = 3'd3,
      I_S_NEXT_PIXEL = 3'd4
   } inner_state_t;

   localparam int SCREEN_W = 160;
   localparam int PLAY_H   = 80;
   localparam int SCREEN_H = 120;

   // Last column, last row of the full sweep, last row of the play field.
   localparam logic [7:0] X_LAST       = 8'(SCREEN_W - 1);
   localparam logic [6:0] Y_SWEEP_LAST = 7'(SCREEN_H - 1);
   localparam logic [6:0] Y_PLAY_LAST  = 7'(PLAY_H - 1);

   // Shorten the frame period by one step, never going below the floor.
   // Comparing against floor+step (instead of subtracting first) keeps the
   // unsigned arithmetic from wrapping.
   function automatic logic [31:0] sped_up_period(
      input logic [31:0] cur,
      input logic [31:0] floor_period,
      input logic [31:0] step
   );
      return (cur >= floor_period + step) ? (cur - step) : floor_period;
   endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// -----------------------------------------------------------------------------
// game_sequencer_if
//   Bundle between the control sequencer and the 160x120 datapath.
//   Datapath -> sequencer : out_x, out_y, sig_collision, sig_next_frame
//   Sequencer -> datapath : core_state, play_state, player_x, player_y,
//                           cycles_per_frame, score
//   Modports:
//     master - the sequencer (drives state and game variables)
//     slave  - the datapath (drives pixel position and event flags)
// -----------------------------------------------------------------------------
interface game_sequencer_if;

   logic [7:0]  out_x;
   logic [6:0]  out_y;
   logic        sig_collision;
   logic        sig_next_frame;

   logic [1:0]  core_state;
   logic [2:0]  play_state;
   logic [7:0]  player_x;
   logic [6:0]  player_y;
   logic [31:0] cycles_per_frame;
   logic [15:0] score;

   modport master (
      input  out_x, out_y, sig_collision, sig_next_frame,
      output core_state, play_state, player_x, player_y,
             cycles_per_frame, score
   );

   modport slave (
      output out_x, out_y, sig_collision, sig_next_frame,
      input  core_state, play_state, player_x, player_y,
             cycles_per_frame, score
   );

endinterface

// File: rtl/game_sequencer_key_sync_edge.sv
// -----------------------------------------------------------------------------
// key_sync_edge
//   Two-flop synchroniser for an asynchronous push button followed by a
//   rising-edge detector.
//   Ports:
//     clock   in  system clock
//     resetn  in  asynchronous active-low reset
//     key_in  in  raw button, active-high, asynchronous to clock
//     level   out synchronised button level (two clocks of latency)
//     pulse   out one-cycle pulse on each rising edge of level
// -----------------------------------------------------------------------------
module key_sync_edge (
   input  logic clock,
   input  logic resetn,
   input  logic key_in,
   output logic level,
   output logic pulse
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbour; blocking here would collapse the
   // synchroniser chain into a single flop.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= key_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign level = sync_q;
   assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
//   Top-level control for the scrolling game. Runs the outer game FSM
//   (WAIT/PLAY/END) and the per-pixel inner sequence the datapath follows
//   while playing, and owns the player row, frame pacing and survival score.
//   Ports:
//     clock      in   system clock
//     resetn     in   asynchronous active-low reset
//     key_start  in   raw start button (asynchronous, active-high)
//     key_up     in   raw up button    (asynchronous, active-high)
//     key_down   in   raw down button  (asynchronous, active-high)
//     dp         master side of game_sequencer_if (pixel position and
//                event flags in; state, player position, frame period and
//                score out, all registered)
// -----------------------------------------------------------------------------
module game_sequencer
   import game_sequencer_pkg::*;
#(
   parameter logic [7:0]  PLAYER_X          = 8'd20,
   parameter logic [6:0]  PLAYER_Y_INIT     = 7'd36,
   parameter logic [6:0]  PLAYER_Y_MAX      = 7'd72,
   parameter logic [31:0] FRAME_CYCLES_INIT = 32'd833333,
   parameter logic [31:0] FRAME_CYCLES_MIN  = 32'd208333,
   parameter logic [31:0] SPEED_STEP        = 32'd4096,
   parameter logic [7:0]  FRAMES_PER_STEP   = 8'd64
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             key_start,
   input  logic             key_up,
   input  logic             key_down,
   game_sequencer_if.master dp
);

   // ---------------------------------------------------------------- keys
   logic start_level, start_pulse;
   logic up_level,    up_pulse;
   logic down_level,  down_pulse;

   key_sync_edge u_sync_start (
      .clock  (clock),
      .resetn (resetn),
      .key_in (key_start),
      .level  (start_level),
      .pulse  (start_pulse)
   );

   key_sync_edge u_sync_up (
      .clock  (clock),
      .resetn (resetn),
      .key_in (key_up),
      .level  (up_level),
      .pulse  (up_pulse)
   );

   key_sync_edge u_sync_down (
      .clock  (clock),
      .resetn (resetn),
      .key_in (key_down),
      .level  (down_level),
      .pulse  (down_pulse)
   );

   // Start is edge-triggered, movement is level-sampled at the frame commit;
   // the other outputs of each synchroniser are deliberately left unused.
   logic unused_key_outputs;
   assign unused_key_outputs = start_level ^ up_pulse ^ down_pulse;

   // ------------------------------------------------------ pixel decoding
   logic sweep_done;   // last pixel of the full 160x120 sweep
   logic play_last;    // last pixel of the 160x80 play field

   assign sweep_done = (dp.out_x == X_LAST) && (dp.out_y == Y_SWEEP_LAST);
   assign play_last  = (dp.out_x == X_LAST) && (dp.out_y == Y_PLAY_LAST);

   // ------------------------------------------------------------ registers
   outer_state_t core_q,    core_d;
   inner_state_t play_q,    play_d;
   logic [7:0]   player_x_q;
   logic [6:0]   player_y_q, player_y_d;
   logic [31:0]  cpf_q,     cpf_d;
   logic [15:0]  score_q,   score_d;
   logic [7:0]   frame_ctr_q, frame_ctr_d;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         core_q      <= O_S_WAIT;
         play_q      <= I_S_INITIALIZE;
         player_x_q  <= PLAYER_X;
         player_y_q  <= PLAYER_Y_INIT;
         cpf_q       <= FRAME_CYCLES_INIT;
         score_q     <= '0;
         frame_ctr_q <= '0;
      end else begin
         core_q      <= core_d;
         play_q      <= play_d;
         player_x_q  <= PLAYER_X;
         player_y_q  <= player_y_d;
         cpf_q       <= cpf_d;
         score_q     <= score_d;
         frame_ctr_q <= frame_ctr_d;
      end
   end

   // ------------------------------------------------------ next-state logic
   logic move_up, move_down;

   assign move_up   = up_level & ~down_level;
   assign move_down = down_level & ~up_level;

   always_comb begin
      // NOTE: every signal assigned below gets its hold value first, so no
      // path through the case statements can leave one unassigned and infer
      // a latch.
      core_d      = core_q;
      play_d      = play_q;
      player_y_d  = player_y_q;
      cpf_d       = cpf_q;
      score_d     = score_q;
      frame_ctr_d = frame_ctr_q;

      case (core_q)
         O_S_WAIT: begin
            play_d = I_S_INITIALIZE;
            // A start press that misses the end of the sweep is dropped;
            // the player must press again.
            if (start_pulse && sweep_done) begin
               core_d      = O_S_PLAY;
               score_d     = '0;
               frame_ctr_d = '0;
               cpf_d       = FRAME_CYCLES_INIT;
               player_y_d  = PLAYER_Y_INIT;
            end
         end

         O_S_PLAY: begin
            // Collision outranks everything, including a frame commit in
            // the same cycle.
            if (dp.sig_collision) begin
               core_d = O_S_END;
               play_d = I_S_INITIALIZE;
            end else begin
               case (play_q)
                  I_S_INITIALIZE: play_d = I_S_READ_NEXT;
                  I_S_READ_NEXT:  play_d = I_S_READ;
                  I_S_READ:       play_d = I_S_WRITE_HERE;
                  I_S_WRITE_HERE: play_d = I_S_NEXT_PIXEL;
                  I_S_NEXT_PIXEL: begin
                     if (!play_last) begin
                        play_d = I_S_READ_NEXT;
                     end else if (dp.sig_next_frame) begin
                        // Frame commit: the only place score, player row
                        // and pacing change during play.
                        play_d = I_S_INITIALIZE;

                        if (score_q != 16'hFFFF) begin
                           score_d = score_q + 16'd1;
                        end

                        if (move_up && (player_y_q != 7'd0)) begin
                           player_y_d = player_y_q - 7'd1;
                        end else if (move_down && (player_y_q < PLAYER_Y_MAX)) begin
                           player_y_d = player_y_q + 7'd1;
                        end

                        if (frame_ctr_q == FRAMES_PER_STEP - 8'd1) begin
                           frame_ctr_d = '0;
                           cpf_d       = sped_up_period(cpf_q, FRAME_CYCLES_MIN,
                                                        SPEED_STEP);
                        end else begin
                           frame_ctr_d = frame_ctr_q + 8'd1;
                        end
                     end
                  end
                  default: play_d = I_S_INITIALIZE;
               endcase
            end
         end

         O_S_END: begin
            play_d = I_S_INITIALIZE;
            if (start_pulse) begin
               core_d = O_S_WAIT;
            end
         end

         default: begin
            core_d = O_S_WAIT;
            play_d = I_S_INITIALIZE;
         end
      endcase
   end

   // ------------------------------------------------------------- outputs
   assign dp.core_state       = core_q;
   assign dp.play_state       = play_q;
   assign dp.player_x         = player_x_q;
   assign dp.player_y         = player_y_q;
   assign dp.cycles_per_frame = cpf_q;
   assign dp.score            = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
//   Directed and randomised stimulus for game_sequencer. A behavioural model
//   tracks the game in plain integers: key histories as delay lines, the
//   pixel sequence as a phase number, and the frame-commit rules as
//   arithmetic. All outputs are compared on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

   localparam int P_Y_INIT  = 36;
   localparam int P_Y_MAX   = 72;
   localparam int P_X       = 20;
   localparam int CPF_INIT  = 833333;
   localparam int CPF_MIN   = 208333;
   localparam int CPF_STEP  = 4096;
   localparam int FR_STEP   = 64;

   logic clock = 1'b0;
   logic resetn;
   logic key_start, key_up, key_down;

   always #5 clock = ~clock;

   game_sequencer_if dp ();

   game_sequencer dut (
      .clock     (clock),
      .resetn    (resetn),
      .key_start (key_start),
      .key_up    (key_up),
      .key_down  (key_down),
      .dp        (dp)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state. Phase: 0=INITIALIZE, 1..4 = the four pixel steps.
   int m_core, m_phase, m_y, m_cpf, m_score, m_frames;
   bit st1, st2, st3;   // key_start delay line (st2 = synchronised level)
   bit up1, up2, dn1, dn2;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_core = 0; m_phase = 0; m_y = P_Y_INIT; m_cpf = CPF_INIT;
      m_score = 0; m_frames = 0;
      st1 = 0; st2 = 0; st3 = 0; up1 = 0; up2 = 0; dn1 = 0; dn2 = 0;
   endfunction

   // Advance the model across one rising edge using the current inputs.
   function automatic void model_clock();
      bit start_edge = st2 && !st3;
      bit sweep_end  = (dp.out_x == 159) && (dp.out_y == 119);
      bit field_end  = (dp.out_x == 159) && (dp.out_y == 79);
      if (m_core == 0) begin
         m_phase = 0;
         if (start_edge && sweep_end) begin
            m_core = 1; m_score = 0; m_frames = 0;
            m_cpf = CPF_INIT; m_y = P_Y_INIT;
         end
      end else if (m_core == 1) begin
         if (dp.sig_collision) begin
            m_core = 2; m_phase = 0;
         end else if (m_phase == 4) begin
            if (!field_end) m_phase = 1;
            else if (dp.sig_next_frame) begin
               m_phase = 0;
               if (m_score < 65535) m_score++;
               if (up2 && !dn2 && m_y > 0) m_y--;
               else if (dn2 && !up2 && m_y < P_Y_MAX) m_y++;
               m_frames++;
               if (m_frames == FR_STEP) begin
                  m_frames = 0;
                  m_cpf = (m_cpf - CPF_STEP >= CPF_MIN) ? m_cpf - CPF_STEP : CPF_MIN;
               end
            end
         end else begin
            m_phase++;
         end
      end else begin
         m_phase = 0;
         if (start_edge) m_core = 0;
      end
      st3 = st2; st2 = st1; st1 = key_start;
      up2 = up1; up1 = key_up;
      dn2 = dn1; dn1 = key_down;
   endfunction

   task automatic check_outputs();
      chk("core_state", {30'd0, dp.core_state}, m_core);
      chk("play_state", {29'd0, dp.play_state}, m_phase);
      chk("player_x",   {24'd0, dp.player_x}, P_X);
      chk("player_y",   {25'd0, dp.player_y}, m_y);
      chk("cycles_per_frame", dp.cycles_per_frame, m_cpf);
      chk("score",      {16'd0, dp.score}, m_score);
   endtask

   // One clock: model follows the edge, outputs checked on the falling edge.
   task automatic step();
      if (!resetn) model_reset();
      else model_clock();
      @(posedge clock);
      @(negedge clock);
      check_outputs();
   endtask

   task automatic run_commits(input int n);
      int target = m_score + n;
      int guard  = 0;
      dp.out_x = 8'd159; dp.out_y = 7'd79; dp.sig_next_frame = 1'b1;
      while (m_score < target && guard < n * 8 + 20) begin
         step();
         guard++;
      end
      chk("commit_count", {16'd0, dp.score}, target);
   endtask

   initial begin
      int saved, guard;

      resetn = 1'b0;
      key_start = 1'b0; key_up = 1'b0; key_down = 1'b0;
      dp.out_x = '0; dp.out_y = '0;
      dp.sig_collision = 1'b0; dp.sig_next_frame = 1'b0;
      model_reset();
      repeat (3) step();
      chk("reset_cpf", dp.cycles_per_frame, CPF_INIT);
      resetn = 1'b1;
      repeat (2) step();

      // Start press away from the end of the sweep is discarded.
      dp.out_x = 8'd100; dp.out_y = 7'd50;
      key_start = 1'b1;
      repeat (4) step();
      key_start = 1'b0;
      repeat (3) step();
      chk("start_discarded", {30'd0, dp.core_state}, 0);

      // Start at 159/119: two synchroniser clocks, then PLAY on the third.
      dp.out_x = 8'd159; dp.out_y = 7'd119;
      key_start = 1'b1;
      step(); step();
      chk("start_sync_wait", {30'd0, dp.core_state}, 0);
      step();
      chk("start_play", {30'd0, dp.core_state}, 1);
      chk("start_score", {16'd0, dp.score}, 0);
      chk("start_player_y", {25'd0, dp.player_y}, P_Y_INIT);
      repeat (5) step();
      key_start = 1'b0;

      // Pixel sequence away from the last pixel, then hold at the last one.
      dp.out_x = 8'd20; dp.out_y = 7'd30;
      repeat (12) step();
      dp.out_x = 8'd159; dp.out_y = 7'd79; dp.sig_next_frame = 1'b0;
      repeat (14) step();
      chk("hold_next_pixel", {29'd0, dp.play_state}, 4);
      dp.sig_next_frame = 1'b1;
      step();
      chk("commit_play_state", {29'd0, dp.play_state}, 0);
      chk("commit_score", {16'd0, dp.score}, 1);

      // Movement: up, both keys (no change), up to the floor.
      key_up = 1'b1;
      run_commits(20);
      key_down = 1'b1;
      saved = m_y;
      run_commits(5);
      chk("both_keys_hold", {25'd0, dp.player_y}, saved);
      key_down = 1'b0;
      run_commits(20);
      chk("up_floor", {25'd0, dp.player_y}, 0);
      key_up = 1'b0;

      // First speed-up after 64 committed frames.
      run_commits(FR_STEP - m_score);
      chk("first_speedup", dp.cycles_per_frame, 829237);

      key_down = 1'b1;
      run_commits(80);
      chk("down_ceiling", {25'd0, dp.player_y}, P_Y_MAX);
      key_down = 1'b0;

      // Run to the period floor with random key activity.
      guard = 0;
      dp.out_x = 8'd159; dp.out_y = 7'd79; dp.sig_next_frame = 1'b1;
      while (m_cpf != CPF_MIN && guard < 60000) begin
         if ($urandom_range(0, 15) == 0) key_up = 1'($urandom);
         if ($urandom_range(0, 15) == 0) key_down = 1'($urandom);
         step();
         guard++;
      end
      chk("clamp_min", dp.cycles_per_frame, CPF_MIN);
      run_commits(FR_STEP);
      chk("clamp_stays", dp.cycles_per_frame, CPF_MIN);

      // Randomised play: coordinates, frame flag, keys; no collisions.
      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(0, 19))
            0, 1, 2, 3, 4: begin dp.out_x = 8'd159; dp.out_y = 7'd79; end
            5:             begin dp.out_x = 8'd159; dp.out_y = 7'd119; end
            default: begin
               dp.out_x = 8'($urandom_range(0, 159));
               dp.out_y = 7'($urandom_range(0, 119));
            end
         endcase
         dp.sig_next_frame = 1'($urandom);
         if ($urandom_range(0, 7) == 0) key_up = 1'($urandom);
         if ($urandom_range(0, 7) == 0) key_down = 1'($urandom);
         if ($urandom_range(0, 7) == 0) key_start = 1'($urandom);
         step();
      end
      key_up = 1'b0; key_down = 1'b0; key_start = 1'b0;
      chk("random_still_play", {30'd0, dp.core_state}, 1);

      // Collision in the same cycle as a frame commit.
      dp.out_x = 8'd159; dp.out_y = 7'd79; dp.sig_next_frame = 1'b1;
      guard = 0;
      while (m_phase != 4 && guard < 20) begin
         step();
         guard++;
      end
      saved = m_score;
      dp.sig_collision = 1'b1;
      step();
      dp.sig_collision = 1'b0;
      chk("collision_end", {30'd0, dp.core_state}, 2);
      chk("collision_score", {16'd0, dp.score}, saved);

      // END -> WAIT on start; holding the key must not re-enter PLAY.
      key_start = 1'b1;
      repeat (3) step();
      chk("end_to_wait", {30'd0, dp.core_state}, 0);
      chk("wait_score_kept", {16'd0, dp.score}, saved);
      dp.out_x = 8'd159; dp.out_y = 7'd119;
      repeat (8) step();
      chk("held_no_restart", {30'd0, dp.core_state}, 0);
      key_start = 1'b0;
      repeat (2) step();

      // Re-enter PLAY, build score 5, stop in READ, then reset asynchronously.
      key_start = 1'b1;
      guard = 0;
      while (m_core != 1 && guard < 10) begin
         step();
         guard++;
      end
      key_start = 1'b0;
      chk("reenter_play", {30'd0, dp.core_state}, 1);
      run_commits(5);
      dp.out_x = 8'd10; dp.out_y = 7'd10; dp.sig_next_frame = 1'b0;
      guard = 0;
      while (m_phase != 2 && guard < 10) begin
         step();
         guard++;
      end
      chk("pre_reset_read", {29'd0, dp.play_state}, 2);
      chk("pre_reset_score", {16'd0, dp.score}, 5);

      #2;
      resetn = 1'b0;
      #1;
      chk("arst_core", {30'd0, dp.core_state}, 0);
      chk("arst_play", {29'd0, dp.play_state}, 0);
      chk("arst_player_x", {24'd0, dp.player_x}, P_X);
      chk("arst_player_y", {25'd0, dp.player_y}, P_Y_INIT);
      chk("arst_cpf", dp.cycles_per_frame, CPF_INIT);
      chk("arst_score", {16'd0, dp.score}, 0);
      model_reset();
      @(negedge clock);
      repeat (2) step();
      resetn = 1'b1;
      repeat (4) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
